fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h5400_0000, encoding injected into IF/ID on bubble or squash.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load_bubble  input  1  hazard unit: load-use stall request for the current fetch.
REQ-006 branch_bubble  input  1  hazard unit: current fetch is an unresolved branch.
REQ-007 br_resolved  input  1  one-cycle pulse: branch outcome valid.
REQ-008 br_taken  input  1  branch outcome, qualified by br_resolved.
REQ-009 br_target  input  32  branch target, qualified by br_resolved.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 imem_addr  output  32  fetch address; always equals the PC register.
REQ-012 imem_ready  input  1  imem_data valid this cycle.
REQ-013 imem_data  input  32  fetched instruction.
REQ-014 if_instr  output  32  IF/ID instruction register.
REQ-015 if_pc_plus_4  output  32  IF/ID PC+4 register.
REQ-016 if_valid  output  1  IF/ID holds a real instruction, not a bubble.
REQ-017 bubble_cnt  output  16  count of cycles where IF/ID was loaded with NOP_INSTR.

Function
REQ-018 Two states: RUN and BR_WAIT; a fetch completes in RUN when imem_req and imem_ready are both high.
REQ-019 imem_req SHALL be 1 in RUN and 0 in BR_WAIT or while rst is high (combinational).
REQ-020 RUN, fetch complete, no bubble: if_instr<=imem_data, if_pc_plus_4<=PC+4, if_valid<=1, PC<=PC+4.
REQ-021 RUN, imem_ready low: PC holds, IF/ID<=NOP_INSTR with if_valid<=0; load_bubble/branch_bubble ignored.
REQ-022 RUN, fetch complete, load_bubble high: PC holds, fetched word discarded, IF/ID<=NOP_INSTR, if_valid<=0; refetch of same PC next cycle.
REQ-023 RUN, fetch complete, branch_bubble high, load_bubble low: branch latched as in REQ-020, then next state BR_WAIT.
REQ-024 load_bubble and branch_bubble together: load_bubble wins; branch not accepted, state stays RUN.
REQ-025 BR_WAIT: PC holds, IF/ID<=NOP_INSTR, if_valid<=0 every cycle until br_resolved.
REQ-026 BR_WAIT, br_resolved high: PC<=br_taken ? {br_target[31:2],2'b00} : PC; next state RUN; fetch resumes the following cycle.
REQ-027 RUN, br_resolved high with br_taken high: redirect to target (word-aligned), IF/ID<=NOP_INSTR (squash), overriding REQ-020..024; br_taken low in RUN has no effect.
REQ-028 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000; if_pc_plus_4 wraps identically.
REQ-029 bubble_cnt SHALL increment on every clock edge that loads NOP_INSTR into IF/ID, saturating at 16'hFFFF.
REQ-030 Branch resolution latency: minimum 1 cycle in BR_WAIT; no upper bound.

Reset
REQ-031 rst high at an edge: PC<=RESET_PC, state<=RUN, if_instr<=NOP_INSTR, if_pc_plus_4<=0, if_valid<=0, bubble_cnt<=0.
REQ-032 rst SHALL take priority over all other inputs, including in BR_WAIT or with br_resolved high; a pending branch is abandoned.
REQ-033 First fetch after rst falls SHALL be at RESET_PC.

Verification
REQ-034 Release reset, imem_ready=1 with data 0x20010005 at PC 0 -> imem_addr 0, 4, 8 on successive cycles; if_instr=0x20010005, if_pc_plus_4=4, if_valid=1.
REQ-035 load_bubble high for one cycle at PC 8 -> imem_addr stays 8 two cycles; IF/ID=0x54000000, if_valid=0 once; bubble_cnt=1.
REQ-036 branch_bubble at PC 0x10, br_resolved+br_taken after 3 cycles with br_target 0x43 -> branch in IF/ID, imem_req=0 for 3 cycles, 3 bubbles, next imem_addr 0x40.
REQ-037 Same with br_taken=0 -> next imem_addr 0x14.
REQ-038 load_bubble and branch_bubble together, PC 0x20 -> state RUN, PC holds 0x20, if_valid=0.
REQ-039 rst asserted in BR_WAIT -> next cycle PC=RESET_PC, imem_req=1 after release; PC 0xFFFFFFFC fetch -> next imem_addr 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC and the IF/ID register. It stops
// fetching while a branch is unresolved and inserts NOP bubbles on stalls.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h5400_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_bubble,
  input  logic        branch_bubble,
  input  logic        br_resolved,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus_4,
  output logic        if_valid,
  output logic [15:0] bubble_cnt
);

  typedef enum logic {RUN, BR_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_plus_4_q, if_pc_plus_4_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        load_nop;
  logic [31:0] pc_inc;
  logic [31:0] tgt_aligned;

  assign pc_inc      = pc_q + 32'd4;
  assign tgt_aligned = {br_target[31:2], 2'b00};

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    if_instr_d     = if_instr_q;
    if_pc_plus_4_d = if_pc_plus_4_q;
    if_valid_d     = if_valid_q;
    load_nop       = 1'b1;
    unique case (state_q)
      RUN: begin
        // A taken branch resolving now squashes whatever is being fetched.
        if (br_resolved && br_taken) begin
          pc_d = tgt_aligned;
        end else if (imem_ready && !load_bubble) begin
          load_nop       = 1'b0;
          if_instr_d     = imem_data;
          if_pc_plus_4_d = pc_inc;
          if_valid_d     = 1'b1;
          pc_d           = pc_inc;
          if (branch_bubble) state_d = BR_WAIT;
        end
      end
      BR_WAIT: begin
        if (br_resolved) begin
          state_d = RUN;
          if (br_taken) pc_d = tgt_aligned;
        end
      end
      default: state_d = RUN;
    endcase
    if (load_nop) begin
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end
    bubble_cnt_d = bubble_cnt_q;
    if (load_nop && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      if_instr_q     <= NOP_INSTR;
      if_pc_plus_4_q <= 32'h0;
      if_valid_q     <= 1'b0;
      bubble_cnt_q   <= 16'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      if_instr_q     <= if_instr_d;
      if_pc_plus_4_q <= if_pc_plus_4_d;
      if_valid_q     <= if_valid_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  assign imem_req     = (state_q == RUN) && !rst;
  assign imem_addr    = pc_q;
  assign if_instr     = if_instr_q;
  assign if_pc_plus_4 = if_pc_plus_4_q;
  assign if_valid     = if_valid_q;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural model is checked every cycle,
// and hand-computed literals pin key points of the sequence.
module tb_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h5400_0000;

  logic        clk = 1'b0;
  logic        rst, load_bubble, branch_bubble, br_resolved, br_taken, imem_ready;
  logic [31:0] br_target, imem_data;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc_plus_4;
  logic [15:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .load_bubble(load_bubble), .branch_bubble(branch_bubble),
    .br_resolved(br_resolved), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_data(imem_data), .if_instr(if_instr), .if_pc_plus_4(if_pc_plus_4),
    .if_valid(if_valid), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: the PC, whether fetch is parked on a branch, the IF/ID contents.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_wait, m_valid, m_init = 1'b0;
  logic [15:0] m_cnt;
  logic        m_fetched;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_pc = 32'h0; m_wait = 1'b0;
      m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
    end else if (m_init) begin
      m_fetched = 1'b0;
      if (m_wait) begin
        if (br_resolved) begin
          m_wait = 1'b0;
          if (br_taken) m_pc = br_target & 32'hFFFF_FFFC;
        end
      end else if (br_resolved && br_taken) begin
        m_pc = br_target & 32'hFFFF_FFFC;
      end else if (imem_ready && !load_bubble) begin
        m_fetched = 1'b1;
        m_instr = imem_data;
        m_pp4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
        m_wait = branch_bubble;
      end
      if (m_fetched) m_valid = 1'b1;
      else begin
        m_instr = NOP; m_valid = 1'b0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, !m_wait && !rst});
      chk("imem_addr", imem_addr, m_pc);
      chk("if_instr", if_instr, m_instr);
      chk("if_pc_plus_4", if_pc_plus_4, m_pp4);
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("bubble_cnt", {16'b0, bubble_cnt}, {16'b0, m_cnt});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic idle;
    load_bubble = 0; branch_bubble = 0; br_resolved = 0; br_taken = 0; br_target = 0;
  endtask

  initial begin
    rst = 1; idle; imem_ready = 0; imem_data = 32'h0;
    tick(2);
    chk("rst_req_low", {31'b0, imem_req}, 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_cnt", {16'b0, bubble_cnt}, 32'd0);
    rst = 0; imem_ready = 1; imem_data = 32'h2001_0005;
    #1;
    chk("first_addr", imem_addr, 32'h0);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    tick(1);
    chk("fetch0_instr", if_instr, 32'h2001_0005);
    chk("fetch0_pp4", if_pc_plus_4, 32'h4);
    chk("fetch0_valid", {31'b0, if_valid}, 32'd1);
    chk("addr4", imem_addr, 32'h4);
    tick(1);
    chk("addr8", imem_addr, 32'h8);
    // load-use stall at PC 8
    load_bubble = 1; tick(1); load_bubble = 0;
    chk("lb_addr_hold", imem_addr, 32'h8);
    chk("lb_instr_nop", if_instr, NOP);
    chk("lb_valid", {31'b0, if_valid}, 32'd0);
    chk("lb_cnt", {16'b0, bubble_cnt}, 32'd1);
    tick(2);
    chk("addr10", imem_addr, 32'h10);
    // taken branch at 0x10, resolved in the third wait cycle
    imem_data = 32'hB000_0001; branch_bubble = 1; tick(1); branch_bubble = 0;
    chk("br_instr", if_instr, 32'hB000_0001);
    chk("br_pp4", if_pc_plus_4, 32'h14);
    chk("br_wait_req", {31'b0, imem_req}, 32'd0);
    tick(2);
    br_resolved = 1; br_taken = 1; br_target = 32'h43; tick(1); idle;
    chk("br_taken_addr", imem_addr, 32'h40);
    chk("br_taken_req", {31'b0, imem_req}, 32'd1);
    chk("br_taken_cnt", {16'b0, bubble_cnt}, 32'd4);
    // not-taken branch at 0x40, minimum one wait cycle
    branch_bubble = 1; tick(1); branch_bubble = 0;
    br_resolved = 1; br_taken = 0; br_target = 32'h80; tick(1); idle;
    chk("br_nt_addr", imem_addr, 32'h44);
    // resolution in RUN: not-taken ignored, taken squashes and redirects
    br_resolved = 1; br_taken = 0; br_target = 32'h200; tick(1);
    chk("run_nt_addr", imem_addr, 32'h48);
    br_taken = 1; br_target = 32'h23; load_bubble = 1; tick(1); idle;
    chk("squash_addr", imem_addr, 32'h20);
    chk("squash_valid", {31'b0, if_valid}, 32'd0);
    // both bubbles: load wins, no branch wait
    load_bubble = 1; branch_bubble = 1; tick(1); idle;
    chk("both_addr", imem_addr, 32'h20);
    chk("both_req", {31'b0, imem_req}, 32'd1);
    chk("both_valid", {31'b0, if_valid}, 32'd0);
    // memory not ready: hold, bubble even with branch_bubble up
    imem_ready = 0; branch_bubble = 1; tick(2); idle; imem_ready = 1;
    chk("nrdy_addr", imem_addr, 32'h20);
    chk("nrdy_req", {31'b0, imem_req}, 32'd1);
    // reset while waiting on a branch, with a resolution in the same cycle
    branch_bubble = 1; tick(1); branch_bubble = 0;
    rst = 1; br_resolved = 1; br_taken = 1; br_target = 32'h300; #1;
    chk("rst_comb_req", {31'b0, imem_req}, 32'd0);
    tick(1); idle; rst = 0; #1;
    chk("rst_wait_addr", imem_addr, 32'h0);
    chk("rst_wait_req", {31'b0, imem_req}, 32'd1);
    // PC wraparound
    br_resolved = 1; br_taken = 1; br_target = 32'hFFFF_FFFE; tick(1); idle;
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    tick(1);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pp4", if_pc_plus_4, 32'h0);
    // bubble counter saturation
    imem_ready = 0; tick(65540); imem_ready = 1;
    chk("cnt_sat", {16'b0, bubble_cnt}, 32'h0000_FFFF);
    tick(1);
    chk("cnt_sat_hold", {16'b0, bubble_cnt}, 32'h0000_FFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
